online_adder_checker_r4: RTL
============================

// Module: online_adder_checker_r4
// PURPOSE
//  Test sequencer and checker that sits downstream of the radix-4 test-vector table and drives the online adder under test.
//  Steps testSelect through every test and streams x/y digits MSD-first into the adder.
//  Compares each result digit against expected z and reports pass/fail bytes to the UART transmitter.
// PARAMETERS
//  N      6  digits per operand
//  C      3  bits per digit, two's complement, digit set {-3..3}; C<=4
//  DELTA  2  adder online delay in cycles; first result digit appears DELTA-1 cycles after first input digit
//  NTESTS 8  tests run, 1..11; index 0 -> select 0, index i>=1 -> select 1<<(i-1)
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        one-cycle pulse; starts a full run
//  test_sel  out  10       drives the vector table select input
//  x_vec     in   N*C      operand x from the table, digit 0 (MSD) in the top C bits
//  y_vec     in   N*C      operand y, same layout as x_vec
//  z_vec     in   (N+1)*C  expected result, N+1 digits, MSD in the top C bits
//  adder_clr out  1        one-cycle synchronous clear to the adder
//  xd        out  C        x digit to the adder
//  yd        out  C        y digit to the adder
//  zd        in   C        result digit from the adder
//  tx_data   out  8        byte to the UART transmitter
//  tx_valid  out  1        tx_data valid
//  tx_ready  in   1        UART accepts the byte
//  busy      out  1        high from start acceptance until done
//  done      out  1        one-cycle pulse when the run completes
//  pass_cnt  out  4        number of passing tests in the current or last run
// BEHAVIOUR
//  Reset: state IDLE; test_sel, xd, yd, tx_data and pass_cnt = 0; adder_clr, tx_valid, busy and done = 0.
//  FSM: IDLE -> SELECT -> CLEAR -> STREAM -> REPORT -> (SELECT | SUMMARY) -> IDLE.
//  IDLE
//   - start=1: clear pass_cnt, set idx=0, busy=1, go to SELECT.
//  SELECT (1 cycle)
//   - test_sel is registered, so the table output is stable in this cycle.
//   - x_vec, y_vec and z_vec are captured at the end of SELECT.
//  CLEAR (1 cycle)
//   - adder_clr=1; per-test fail flag cleared.
//  STREAM (N+DELTA cycles, k=0..N+DELTA-1)
//   - xd/yd = digit k for k<N, 0 otherwise.
//   - For k>=DELTA-1, zd is compared bit-exactly with expected digit k-DELTA+1.
//   - Any mismatch sets the sticky fail flag.
//  REPORT
//   - tx_data = {pass,3'b000,idx[3:0]}, tx_valid=1.
//   - On pass, pass_cnt increments when the byte is accepted.
//   - idx==NTESTS-1 -> SUMMARY; otherwise idx+1 -> SELECT.
//  SUMMARY
//   - tx_data = {4'hA,pass_cnt}.
//   - On acceptance: done=1 for 1 cycle, busy=0, go to IDLE.
//  Handshake
//   - A byte transfers on a clock edge where tx_valid & tx_ready.
//   - tx_valid and tx_data stay stable until the transfer; tx_valid drops the cycle after it.
//   - tx_ready low stalls in REPORT/SUMMARY indefinitely; no streaming occurs while stalled.
//  Boundary conditions
//   - start while busy is ignored.
//   - xd/yd = 0 outside STREAM.
//   - pass_cnt holds its value after done until the next start.
//   - Reset mid-run aborts immediately to the reset values; no partial byte is left valid.
// CONFIGURATION
//  CHECKER_DIAG_EN defined:
//   - Each failing test adds state DIAG after REPORT.
//   - DIAG sends {pos[3:0], zero-extended received digit[3:0]} for the first mismatching digit, using the same handshake.
//   - Passing tests send no extra byte.
//  CHECKER_DIAG_EN undefined:
//   - Exactly one byte per test plus the summary byte.
//   - No first-mismatch position or digit is stored.
// TESTING
//  1 Ideal adder model, tx_ready=1, start -> bytes 0x80..0x87 then 0xA8; done pulse; pass_cnt=8.
//  2 Model corrupts result digit 2 of test 3 -> byte 0x03 in place of 0x83, summary 0xA7; others unchanged.
//  3 tx_ready low for 20 cycles at first REPORT -> tx_valid=1 and tx_data=0x80 stable, test_sel unchanged; sequence resumes on ready.
//  4 reset asserted during STREAM of test 4 -> outputs at reset values same cycle; new start gives the full sequence of scenario 1.
//  5 Extra start pulses during a run -> exactly 9 bytes; a single done pulse.
//  6 CHECKER_DIAG_EN, test 3 digit 2 received as 3'b111 -> bytes 0x03, 0x27; summary 0xA7.

Source files
------------

// File: rtl/online_adder_checker_r4.sv
// online_adder_checker_r4: sequences radix-4 online adder tests and reports pass/fail bytes over a UART handshake
// Ports: clk, reset (async, active-high), start pulse; test_sel drives the vector table, x_vec/y_vec/z_vec
// come back from it; adder_clr/xd/yd drive the adder, zd is its result digit; tx_data/tx_valid/tx_ready
// form the byte handshake; busy, done and pass_cnt report run status.
// Define CHECKER_DIAG_EN to add a first-mismatch byte {pos, digit} after each failing test's report byte.
module online_adder_checker_r4 #(
  parameter int N      = 6,
  parameter int C      = 3,
  parameter int DELTA  = 2,
  parameter int NTESTS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [9:0]           test_sel,
  input  logic [N*C-1:0]       x_vec,
  input  logic [N*C-1:0]       y_vec,
  input  logic [(N+1)*C-1:0]   z_vec,
  output logic                 adder_clr,
  output logic [C-1:0]         xd,
  output logic [C-1:0]         yd,
  input  logic [C-1:0]         zd,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           pass_cnt
);
  localparam int KW = $clog2(N + DELTA + 1);
  typedef enum logic [2:0] {IDLE, SELECT, CLEAR, STREAM, REPORT,
`ifdef CHECKER_DIAG_EN
    DIAG,
`endif
    SUMMARY} state_t;
  state_t st;
  logic [3:0] idx;
  logic [KW-1:0] k;
  logic [N*C-1:0] xr, yr;
  logic [(N+1)*C-1:0] zr;
  logic fail, mis, adv, last;
  logic [C-1:0] xn, yn, ze;
  int kn, kc, j, jc;
`ifdef CHECKER_DIAG_EN
  logic [3:0] pos;
  logic [C-1:0] dig;
`endif
  function automatic logic [9:0] sel(input logic [3:0] i);
    return i == 4'd0 ? 10'd0 : 10'd1 << (i - 4'd1);
  endfunction
  // kc/jc clamp the select indices so the unused ternary arm never reads outside the vectors
  always_comb begin
    kn = int'(k) + 1;
    kc = kn < N ? kn : N - 1;
    xn = kn < N ? xr[(N-1-kc)*C +: C] : '0;
    yn = kn < N ? yr[(N-1-kc)*C +: C] : '0;
    j = int'(k) - DELTA + 1;
    jc = j < 0 ? 0 : j;
    ze = zr[(N-jc)*C +: C];
    mis = st == STREAM && j >= 0 && zd != ze;
    last = idx == 4'(NTESTS - 1);
`ifdef CHECKER_DIAG_EN
    adv = tx_valid && tx_ready && ((st == REPORT && !fail) || st == DIAG);
`else
    adv = tx_valid && tx_ready && st == REPORT;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      idx <= '0;
      k <= '0;
      xr <= '0;
      yr <= '0;
      zr <= '0;
      fail <= 1'b0;
`ifdef CHECKER_DIAG_EN
      pos <= '0;
      dig <= '0;
`endif
      test_sel <= '0;
      adder_clr <= 1'b0;
      xd <= '0;
      yd <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done <= 1'b0;
      adder_clr <= 1'b0;
      case (st)
        IDLE: if (start) begin
          pass_cnt <= '0;
          idx <= '0;
          test_sel <= '0;
          busy <= 1'b1;
          st <= SELECT;
        end
        SELECT: begin
          xr <= x_vec;
          yr <= y_vec;
          zr <= z_vec;
          adder_clr <= 1'b1;
          st <= CLEAR;
        end
        CLEAR: begin
          fail <= 1'b0;
          k <= '0;
          xd <= xr[N*C-1 -: C];
          yd <= yr[N*C-1 -: C];
          st <= STREAM;
        end
        STREAM: begin
          fail <= fail | mis;
`ifdef CHECKER_DIAG_EN
          if (mis && !fail) begin
            pos <= 4'(j);
            dig <= zd;
          end
`endif
          if (k == KW'(N + DELTA - 1)) begin
            xd <= '0;
            yd <= '0;
            tx_valid <= 1'b1;
            tx_data <= {~(fail | mis), 3'b000, idx};
            st <= REPORT;
          end else begin
            k <= k + 1'b1;
            xd <= xn;
            yd <= yn;
          end
        end
        REPORT: if (tx_ready) begin
          tx_valid <= 1'b0;
          pass_cnt <= pass_cnt + 4'(tx_data[7]);
`ifdef CHECKER_DIAG_EN
          if (fail) st <= DIAG;
`endif
        end
`ifdef CHECKER_DIAG_EN
        // the diag byte is loaded one cycle after the report byte so tx_valid drops in between
        DIAG: if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data <= {pos, 4'(dig)};
        end else if (tx_ready) tx_valid <= 1'b0;
`endif
        SUMMARY: if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data <= {4'hA, pass_cnt};
        end else if (tx_ready) begin
          tx_valid <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (adv) begin
        if (last) st <= SUMMARY;
        else begin
          idx <= idx + 4'd1;
          test_sel <= sel(idx + 4'd1);
          st <= SELECT;
        end
      end
    end
endmodule
